// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_scan_ctrl
// Brief    : Round-robin scan controller for an ALE/START/EOC/OE style ADC.
//            Optional EOC watchdog compiled in with `define ADC_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module adc_scan_ctrl #(
    parameter int CH_NUM = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int TO_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [CH_NUM-1:0] ch_en,
    input  logic              eoc,
    input  logic [DATA_W-1:0] adc_d,
    output logic              ale,
    output logic              start,
    output logic              oe,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] dout_ch,
    output logic              dout_vld,
    output logic              busy,
    output logic              timeout_err
);

    localparam int                C_IDX_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [ADDR_W-1:0] C_LAST_INIT = ADDR_W'(CH_NUM - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEL     = 3'd1,
        STRT    = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4,
        READ    = 3'd5,
        CAP     = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] dout_ch_q, dout_ch_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;
    logic [ADDR_W-1:0] next_ch;
    logic              timeout_hit;

    // Walk downward so the last hit is the nearest enabled channel after last_q.
    always_comb begin
        int idx;
        next_ch = last_q;
        for (int k = CH_NUM; k >= 1; k--) begin
            idx = (int'(last_q) + k) % CH_NUM;
            if (ch_en[C_IDX_W'(idx)]) begin
                next_ch = ADDR_W'(idx);
            end
        end
    end

`ifdef ADC_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_err_q, timeout_err_d;

    always_comb begin
        to_cnt_d    = to_cnt_q;
        timeout_hit = 1'b0;
        if (state_q == STRT) begin
            to_cnt_d = '0;
        end else if ((state_q == WAIT_LO) || (state_q == WAIT_HI)) begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_cnt_d == '1) begin
                timeout_hit = 1'b1;
            end
        end
        timeout_err_d = timeout_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        last_d     = last_q;
        dout_d     = dout_q;
        dout_ch_d  = dout_ch_q;
        dout_vld_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (run && (|ch_en)) begin
                    state_d = SEL;
                    addr_d  = next_ch;
                end
            end
            SEL:     state_d = STRT;
            STRT:    state_d = WAIT_LO;
            WAIT_LO: if (!eoc) state_d = WAIT_HI;
            WAIT_HI: if (eoc)  state_d = READ;
            READ:    state_d = CAP;
            CAP: begin
                state_d    = IDLE;
                dout_d     = adc_d;
                dout_ch_d  = addr_q;
                dout_vld_d = 1'b1;
                last_d     = addr_q;
            end
            default: state_d = IDLE;
        endcase
        // Watchdog abandons the conversion but still advances the scan pointer.
        if (timeout_hit) begin
            state_d = IDLE;
            last_d  = addr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            last_q     <= C_LAST_INIT;
            dout_q     <= '0;
            dout_ch_q  <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            dout_q     <= dout_d;
            dout_ch_q  <= dout_ch_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign ale      = (state_q == SEL);
    assign start    = (state_q == STRT);
    assign oe       = (state_q == READ) || (state_q == CAP);
    assign busy     = (state_q != IDLE);
    assign addr     = addr_q;
    assign dout     = dout_q;
    assign dout_ch  = dout_ch_q;
    assign dout_vld = dout_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
`default_nettype none
// Testbench for adc_scan_ctrl: vector table, directed corner cases and a
// randomized scan checked against a channel-selection reference model.
module tb_adc_scan_ctrl;

`ifdef ADC_TIMEOUT_EN
    localparam int C_TO_W = 4;
`else
    localparam int C_TO_W = 8;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       run   = 1'b0;
    logic [7:0] ch_en = 8'h00;
    logic       eoc   = 1'b1;
    logic [7:0] adc_d = 8'h00;
    logic       ale, start, oe, dout_vld, busy, timeout_err;
    logic [2:0] addr, dout_ch;
    logic [7:0] dout;

    int n_chk   = 0;
    int n_pass  = 0;
    int vld_cnt = 0;
    int last_m  = 7;

    adc_scan_ctrl #(
        .CH_NUM(8),
        .ADDR_W(3),
        .DATA_W(8),
        .TO_W  (C_TO_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .ch_en      (ch_en),
        .eoc        (eoc),
        .adc_d      (adc_d),
        .ale        (ale),
        .start      (start),
        .oe         (oe),
        .addr       (addr),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_vld   (dout_vld),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dout_vld) vld_cnt++;
    end

    typedef struct {
        logic [7:0] en;
        logic [7:0] en_mid;
        int         d_lo;
        int         d_hi;
        logic [7:0] data;
        logic [2:0] exp_ch;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // First enabled channel strictly after 'last', wrapping 7 -> 0.
    function automatic logic [2:0] model_next(input int last, input logic [7:0] en);
        int idx;
        for (int k = 1; k <= 8; k++) begin
            idx = (last + k) % 8;
            if (en[idx]) return 3'(idx);
        end
        return 3'(last);
    endfunction

    task automatic wait_ale();
        int n;
        n = 0;
        while (!ale && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ale_seen", {31'd0, ale}, 1);
    endtask

    task automatic run_conv(input logic [7:0] en, input logic [7:0] en_mid, input int d_lo,
                            input int d_hi, input logic [7:0] data, input logic [2:0] exp_ch);
        int n;
        int n_oe;
        int v0;
        bit bad;
        v0    = vld_cnt;
        ch_en = en;
        run   = 1'b1;
        adc_d = data;
        wait_ale();
        check("sel_addr", {29'd0, addr}, {29'd0, exp_ch});
        run = 1'b0;
        @(negedge clk);
        check("strt", {27'd0, start, ale, addr}, {27'd0, 1'b1, 1'b0, exp_ch});
        ch_en = en_mid;
        @(negedge clk);
        bad = 1'b0;
        repeat (d_lo) begin
            if (!busy || ale || start || oe || timeout_err || addr != exp_ch) bad = 1'b1;
            @(negedge clk);
        end
        check("wait_lo_hold", {31'd0, bad}, 0);
        eoc = 1'b0;
        repeat (d_hi) @(negedge clk);
        eoc  = 1'b1;
        n    = 0;
        n_oe = 0;
        while (!dout_vld && n < 20) begin
            @(negedge clk);
            n++;
            if (oe) n_oe++;
        end
        check("vld_seen", {31'd0, dout_vld}, 1);
        check("oe_cycles", n_oe, 2);
        check("dout", {21'd0, dout_ch, dout}, {21'd0, exp_ch, data});
        check("idle_after", {30'd0, busy, oe}, 0);
        @(negedge clk);
        check("vld_pulse", {30'd0, dout_vld, (vld_cnt == v0 + 1)}, 32'h1);
        check("dout_hold", {21'd0, dout_ch, dout}, {21'd0, exp_ch, data});
        last_m = int'(exp_ch);
    endtask

    vec_t vecs[10];

    initial begin
        logic [7:0] en;
        logic [2:0] exp;
        int         v0;
        int         n;
        bit         bad;

        vecs[0] = '{8'h05, 8'h05, 1, 10, 8'hA5, 3'd0};
        vecs[1] = '{8'h05, 8'h05, 1, 10, 8'hA5, 3'd2};
        vecs[2] = '{8'h05, 8'h05, 1, 10, 8'hA5, 3'd0};
        vecs[3] = '{8'h01, 8'h80, 0, 3,  8'h3C, 3'd0};
        vecs[4] = '{8'h80, 8'h80, 2, 2,  8'hC3, 3'd7};
        vecs[5] = '{8'hFF, 8'hFF, 0, 1,  8'h00, 3'd0};
        vecs[6] = '{8'hFF, 8'h00, 3, 1,  8'hFF, 3'd1};
        vecs[7] = '{8'h60, 8'h60, 1, 1,  8'h5A, 3'd5};
        vecs[8] = '{8'h60, 8'h60, 1, 1,  8'h5A, 3'd6};
        vecs[9] = '{8'h60, 8'h60, 1, 1,  8'h5A, 3'd5};

        // Reset state
        #1;
        check("reset_state", {12'd0, ale, start, oe, busy, dout_vld, timeout_err, addr, dout, dout_ch}, 0);
        @(negedge clk);
        reset = 1'b0;

        // No enabled channels: never leaves IDLE
        ch_en = 8'h00;
        run   = 1'b1;
        bad   = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (busy || ale || start || oe) bad = 1'b1;
        end
        check("no_channels_idle", {31'd0, bad}, 0);
        run = 1'b0;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].en, vecs[i].en_mid, vecs[i].d_lo, vecs[i].d_hi, vecs[i].data, vecs[i].exp_ch);
        end

        // Asynchronous reset during WAIT_HI
        ch_en = 8'h41;
        run   = 1'b1;
        wait_ale();
        check("pre_rst_addr", {29'd0, addr}, 6);
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        eoc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", {30'd0, busy, (dout != 8'h00)}, 32'h3);
        #2 reset = 1'b1;
        #1;
        check("async_reset", {12'd0, ale, start, oe, busy, dout_vld, timeout_err, addr, dout, dout_ch}, 0);
        @(negedge clk);
        reset  = 1'b0;
        eoc    = 1'b1;
        last_m = 7;
        run_conv(8'h41, 8'h41, 1, 3, 8'h11, 3'd0);

`ifdef ADC_TIMEOUT_EN
        // Watchdog with eoc stuck high
        v0    = vld_cnt;
        ch_en = 8'h05;
        exp   = model_next(last_m, 8'h05);
        run   = 1'b1;
        wait_ale();
        check("to_addr", {29'd0, addr}, {29'd0, exp});
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n = 0;
        while (!timeout_err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to_delay", n, 15);
        check("to_idle", {30'd0, busy, dout_vld}, 0);
        @(negedge clk);
        check("to_pulse", {30'd0, timeout_err, (vld_cnt == v0)}, 32'h1);
        last_m = int'(exp);
        run_conv(8'h05, 8'h05, 1, 2, 8'h77, model_next(last_m, 8'h05));
`else
        // eoc stuck high for 1000 cycles: must keep waiting, then still complete
        exp = model_next(last_m, 8'h24);
        run_conv(8'h24, 8'h24, 1000, 2, 8'h77, exp);
`endif

        // Randomized scan against the reference model
        for (int i = 0; i < 25; i++) begin
            en  = 8'($urandom_range(1, 255));
            exp = model_next(last_m, en);
            run_conv(en, 8'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(1, 5)),
                     8'($urandom), exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
